// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one block-RAM port between an instruction-fetch and a
//            data load/store requester (IDLE -> ACCESS -> WAIT -> RESP).
//            Define MEM_ARB_RR_EN for round-robin conflict resolution;
//            otherwise data always beats inst.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_AW = 7,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_read,
    input  logic [29:0]       inst_address,
    output logic [31:0]       inst_dout,
    output logic              inst_ready,
    input  logic              data_read,
    input  logic [3:0]        data_write,
    input  logic [29:0]       data_address,
    input  logic [31:0]       data_din,
    output logic [31:0]       data_dout,
    output logic              data_ready,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              gnt_data_q, gnt_data_d;
    logic              is_wr_q, is_wr_d;
    logic              mem_en_q, mem_en_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic              inst_ready_q, inst_ready_d;
    logic              data_ready_q, data_ready_d;
    logic [31:0]       inst_dout_q, inst_dout_d;
    logic [31:0]       data_dout_q, data_dout_d;

    logic inst_pend, data_pend, pick_data;

    // Word addresses wrap inside the RAM; the upper bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_address[29:MEM_AW], data_address[29:MEM_AW]};

    assign inst_pend = inst_read;
    assign data_pend = data_read | (|data_write);

`ifdef MEM_ARB_RR_EN
    logic last_data_q, last_data_d;
    assign pick_data = data_pend & (~inst_pend | ~last_data_q);
`else
    assign pick_data = data_pend;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_data_d   = gnt_data_q;
        is_wr_d      = is_wr_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 4'd0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_dout_d  = inst_dout_q;
        data_dout_d  = data_dout_q;
`ifdef MEM_ARB_RR_EN
        last_data_d  = last_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (inst_pend || data_pend) begin
                    state_d    = S_ACCESS;
                    gnt_data_d = pick_data;
                    mem_en_d   = 1'b1;
`ifdef MEM_ARB_RR_EN
                    last_data_d = pick_data;
`endif
                    if (pick_data) begin
                        mem_addr_d = data_address[MEM_AW-1:0];
                        mem_we_d   = data_write;
                        mem_din_d  = data_din;
                        is_wr_d    = |data_write;
                    end else begin
                        mem_addr_d = inst_address[MEM_AW-1:0];
                        is_wr_d    = 1'b0;
                    end
                end
            end
            S_ACCESS: begin
                if (is_wr_q) begin
                    state_d      = S_RESP;
                    data_ready_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                // Last latency cycle: RAM output is valid, capture and respond.
                if (cnt_q == 2'd0) begin
                    state_d = S_RESP;
                    if (gnt_data_q) begin
                        data_dout_d  = mem_dout;
                        data_ready_d = 1'b1;
                    end else begin
                        inst_dout_d  = mem_dout;
                        inst_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            gnt_data_q   <= 1'b0;
            is_wr_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'd0;
            mem_addr_q   <= '0;
            mem_din_q    <= 32'd0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_dout_q  <= 32'd0;
            data_dout_q  <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_data_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_data_q   <= gnt_data_d;
            is_wr_q      <= is_wr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_dout_q  <= inst_dout_d;
            data_dout_q  <= data_dout_d;
`ifdef MEM_ARB_RR_EN
            last_data_q  <= last_data_d;
`endif
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign inst_ready = inst_ready_q;
    assign data_ready = data_ready_q;
    assign inst_dout  = inst_dout_q;
    assign data_dout  = data_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a 1-cycle
//            block-RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MEM_AW = 7;
    localparam int RD_LAT = 1;
`ifdef MEM_ARB_RR_EN
    localparam bit WIN_DATA = 1'b0;
`else
    localparam bit WIN_DATA = 1'b1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_read;
    logic [29:0]       inst_address;
    logic [31:0]       inst_dout;
    logic              inst_ready;
    logic              data_read;
    logic [3:0]        data_write;
    logic [29:0]       data_address;
    logic [31:0]       data_din;
    logic [31:0]       data_dout;
    logic              data_ready;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    logic              tb_load;
    logic [31:0]       ram [0:(1<<MEM_AW)-1];
    int                n_checks = 0;
    int                n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .inst_read(inst_read), .inst_address(inst_address),
        .inst_dout(inst_dout), .inst_ready(inst_ready),
        .data_read(data_read), .data_write(data_write),
        .data_address(data_address), .data_din(data_din),
        .data_dout(data_dout), .data_ready(data_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Block-RAM model, read-before-write, one cycle read latency
    always @(posedge clk) begin
        if (tb_load) begin
            ram[0] <= 32'h0000_0000;
            ram[5] <= 32'hDEAD_BEEF;
            ram[6] <= 32'hCAFE_F00D;
            ram[9] <= 32'hAABB_CCDD;
        end else if (mem_en) begin
            mem_dout <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; tb_load = 1'b1;
        inst_read = 1'b0; inst_address = '0;
        data_read = 1'b0; data_write = 4'd0; data_address = '0; data_din = 32'd0;
        cyc; cyc;

        // Conflict from reset: data wins first
        cyc;
        rst = 1'b0; tb_load = 1'b0;
        check("rst_mem_en",     32'(mem_en),     32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_din",    mem_din,         32'd0);
        check("rst_inst_ready", 32'(inst_ready), 32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_inst_dout",  inst_dout,       32'd0);
        check("rst_data_dout",  data_dout,       32'd0);
        inst_read = 1'b1; inst_address = 30'd6;
        data_read = 1'b1; data_address = 30'd9;
        check("idle_no_en", 32'(mem_en), 32'd0);
        cyc; // T+1
        check("conf_en",   32'(mem_en),   32'd1);
        check("conf_addr", 32'(mem_addr), 32'd9);
        check("conf_we",   32'(mem_we),   32'd0);
        cyc; // T+2
        check("conf_wait_en",  32'(mem_en),     32'd0);
        check("conf_wait_rdy", 32'(data_ready), 32'd0);
        cyc; // T+3
        check("conf_drdy",      32'(data_ready), 32'd1);
        check("conf_irdy_0",    32'(inst_ready), 32'd0);
        check("conf_ddout",     data_dout,       32'hAABB_CCDD);
        cyc; // T+4 both still pending
        check("conf_drdy_1cyc", 32'(data_ready), 32'd0);
        check("conf_idle_en",   32'(mem_en),     32'd0);
        cyc; // T+5
        check("conf2_en",   32'(mem_en),   32'd1);
        check("conf2_addr", 32'(mem_addr), WIN_DATA ? 32'd9 : 32'd6);
        cyc; cyc; // T+7
        check("conf2_win_rdy",  32'(WIN_DATA ? data_ready : inst_ready), 32'd1);
        check("conf2_lose_rdy", 32'(WIN_DATA ? inst_ready : data_ready), 32'd0);
        cyc; // T+8: winner was held through its ready, drop it now
        if (WIN_DATA) data_read = 1'b0; else inst_read = 1'b0;
        cyc; // T+9
        check("conf3_en",   32'(mem_en),   32'd1);
        check("conf3_addr", 32'(mem_addr), WIN_DATA ? 32'd6 : 32'd9);
        cyc; cyc; // T+11
        check("conf3_rdy",   32'(WIN_DATA ? inst_ready : data_ready), 32'd1);
        check("conf3_idout", inst_dout, 32'hCAFE_F00D);
        check("conf3_ddout", data_dout, 32'hAABB_CCDD);
        cyc; // T+12: loser was held through its ready
        inst_read = 1'b0; data_read = 1'b0;
        check("held_no_regrant", 32'(mem_en), 32'd0);
        check("held_rdy_1cyc",   32'(inst_ready | data_ready), 32'd0);
        cyc;
        check("held_idle_en", 32'(mem_en), 32'd0);

        // Inst-only fetch of word 5
        cyc;
        inst_read = 1'b1; inst_address = 30'd5;
        cyc;
        check("fetch_en",   32'(mem_en),   32'd1);
        check("fetch_addr", 32'(mem_addr), 32'd5);
        check("fetch_we",   32'(mem_we),   32'd0);
        cyc;
        check("fetch_wait_rdy", 32'(inst_ready), 32'd0);
        check("fetch_dout_hold", inst_dout, 32'hCAFE_F00D);
        cyc;
        check("fetch_rdy",  32'(inst_ready), 32'd1);
        check("fetch_drdy", 32'(data_ready), 32'd0);
        check("fetch_dout", inst_dout, 32'hDEAD_BEEF);
        cyc;
        inst_read = 1'b0;
        check("fetch_rdy_1cyc", 32'(inst_ready), 32'd0);
        check("fetch_no_regrant", 32'(mem_en), 32'd0);

        // Partial store to word 9, then reload
        cyc;
        data_write = 4'b0011; data_din = 32'h1234_5678; data_address = 30'd9;
        cyc;
        data_din = 32'hFFFF_FFFF; data_write = 4'b1111; data_address = 30'd5;
        check("st_en",   32'(mem_en),   32'd1);
        check("st_we",   32'(mem_we),   32'b0011);
        check("st_addr", 32'(mem_addr), 32'd9);
        check("st_din",  mem_din,       32'h1234_5678);
        cyc;
        check("st_rdy",       32'(data_ready), 32'd1);
        check("st_en_off",    32'(mem_en),     32'd0);
        check("st_dout_hold", data_dout,       32'hAABB_CCDD);
        cyc;
        data_write = 4'd0; data_read = 1'b1; data_din = 32'd0; data_address = 30'd9;
        check("st_rdy_1cyc", 32'(data_ready), 32'd0);
        cyc;
        check("ld_we", 32'(mem_we), 32'd0);
        cyc; cyc;
        check("ld_rdy",  32'(data_ready), 32'd1);
        check("ld_dout", data_dout, 32'hAABB_5678);
        cyc;
        data_read = 1'b0;

        // Reset during WAIT
        cyc;
        inst_read = 1'b1; inst_address = 30'd6;
        cyc; cyc;
        rst = 1'b1;
        cyc;
        rst = 1'b0; inst_read = 1'b0;
        check("mid_rst_irdy",  32'(inst_ready), 32'd0);
        check("mid_rst_idout", inst_dout,       32'd0);
        check("mid_rst_ddout", data_dout,       32'd0);
        check("mid_rst_en",    32'(mem_en),     32'd0);
        check("mid_rst_addr",  32'(mem_addr),   32'd0);
        cyc;
        check("mid_rst_no_rdy", 32'(inst_ready), 32'd0);
        data_read = 1'b1; data_address = 30'd9;
        cyc; cyc; cyc;
        check("mid_rst_mem", data_dout, 32'hAABB_5678);
        cyc;
        data_read = 1'b0;

        // Address wrap: word 0x80 aliases word 0
        cyc;
        data_write = 4'hF; data_din = 32'h0BAD_F00D; data_address = 30'h80;
        cyc;
        check("wrap_addr", 32'(mem_addr), 32'd0);
        check("wrap_en",   32'(mem_en),   32'd1);
        cyc;
        check("wrap_rdy", 32'(data_ready), 32'd1);
        cyc;
        data_write = 4'd0; data_read = 1'b1; data_address = 30'd0;
        cyc;
        check("wrap_ld_addr", 32'(mem_addr), 32'd0);
        cyc; cyc;
        check("wrap_ld_dout", data_dout, 32'h0BAD_F00D);
        cyc;
        data_read = 1'b0;
        cyc;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
